// File: rtl/fpnew_result_reorder.sv
// rtl/fpnew_result_reorder.sv - in-order retirement buffer for out-of-order FPU opgroup results
module fpnew_result_reorder #(
    parameter  int unsigned Width   = 32,
    parameter  int unsigned Depth   = 4,
    localparam int unsigned IdWidth = $clog2(Depth)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               flush_i,
    input  logic               alloc_valid_i,
    output logic               alloc_ready_o,
    output logic [IdWidth-1:0] alloc_id_o,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [Width-1:0]   result_i,
    input  logic [4:0]         status_i,
    input  logic               extension_bit_i,
    input  logic [IdWidth-1:0] id_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [Width-1:0]   result_o,
    output logic [4:0]         status_o,
    output logic               extension_bit_o,
    output logic [4:0]         fflags_o,
    input  logic               fflags_clr_i,
    output logic               busy_o
);
    localparam int unsigned CntW = IdWidth + 1;
    localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

    logic [Depth-1:0]   alloc_q;
    logic [Depth-1:0]   done_q;
    logic [Depth-1:0]   ext_q;
    logic [Width-1:0]   result_q [Depth];
    logic [4:0]         status_q [Depth];
    logic [IdWidth-1:0] head_q;
    logic [IdWidth-1:0] tail_q;
    logic [CntW-1:0]    cnt_q;
    logic [4:0]         fflags_q;

    logic alloc_fire;
    logic comp_fire;
    logic retire_fire;

    assign alloc_ready_o   = (cnt_q != FullCnt);
    assign alloc_id_o      = tail_q;
    assign in_ready_o      = 1'b1;
    assign out_valid_o     = alloc_q[head_q] & done_q[head_q];
    assign result_o        = result_q[head_q];
    assign status_o        = status_q[head_q];
    assign extension_bit_o = ext_q[head_q];
    assign fflags_o        = fflags_q;
    assign busy_o          = (cnt_q != '0);

    // Everything that happens in a flush cycle is discarded, including a retire.
    assign alloc_fire  = alloc_valid_i & alloc_ready_o & ~flush_i;
    assign comp_fire   = in_valid_i & alloc_q[id_i] & ~done_q[id_i] & ~flush_i;
    assign retire_fire = out_valid_o & out_ready_i & ~flush_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            alloc_q <= '0;
            done_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            cnt_q   <= '0;
        end else if (flush_i) begin
            alloc_q <= '0;
            done_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            cnt_q   <= '0;
        end else begin
            // Retire, completion and alloc always address distinct slots.
            if (retire_fire) begin
                alloc_q[head_q] <= 1'b0;
                done_q[head_q]  <= 1'b0;
                head_q          <= head_q + IdWidth'(1);
            end
            if (comp_fire) begin
                done_q[id_i] <= 1'b1;
            end
            if (alloc_fire) begin
                alloc_q[tail_q] <= 1'b1;
                done_q[tail_q]  <= 1'b0;
                tail_q          <= tail_q + IdWidth'(1);
            end
            case ({alloc_fire, retire_fire})
                2'b10:   cnt_q <= cnt_q + CntW'(1);
                2'b01:   cnt_q <= cnt_q - CntW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ext_q <= '0;
            for (int i = 0; i < int'(Depth); i++) begin
                result_q[i] <= '0;
                status_q[i] <= '0;
            end
        end else if (comp_fire) begin
            result_q[id_i] <= result_i;
            status_q[id_i] <= status_i;
            ext_q[id_i]    <= extension_bit_i;
        end
    end

    // A clear coincident with a retire keeps only the retiring status.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fflags_q <= '0;
        end else if (fflags_clr_i) begin
            fflags_q <= retire_fire ? status_o : 5'd0;
        end else if (retire_fire) begin
            fflags_q <= fflags_q | status_o;
        end
    end
endmodule

// File: tb/tb_fpnew_result_reorder.sv
// tb/tb_fpnew_result_reorder.sv - randomized and directed bench for fpnew_result_reorder
module tb_fpnew_result_reorder;
    localparam int W  = 32;
    localparam int D  = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          alloc_valid = 1'b0;
    logic          in_valid = 1'b0;
    logic          ext_in = 1'b0;
    logic          out_ready = 1'b0;
    logic          fflags_clr = 1'b0;
    logic [W-1:0]  res_in = '0;
    logic [4:0]    st_in = '0;
    logic [IW-1:0] id_in = '0;

    logic          alloc_ready_o;
    logic [IW-1:0] alloc_id_o;
    logic          in_ready_o;
    logic          out_valid_o;
    logic [W-1:0]  result_o;
    logic [4:0]    status_o;
    logic          extension_bit_o;
    logic [4:0]    fflags_o;
    logic          busy_o;

    fpnew_result_reorder #(.Width(W), .Depth(D)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .flush_i        (flush),
        .alloc_valid_i  (alloc_valid),
        .alloc_ready_o  (alloc_ready_o),
        .alloc_id_o     (alloc_id_o),
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready_o),
        .result_i       (res_in),
        .status_i       (st_in),
        .extension_bit_i(ext_in),
        .id_i           (id_in),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready),
        .result_o       (result_o),
        .status_o       (status_o),
        .extension_bit_o(extension_bit_o),
        .fflags_o       (fflags_o),
        .fflags_clr_i   (fflags_clr),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    bit cmp_en = 1'b0;

    // Model: slot table plus head index and occupancy count; tail is derived.
    bit         m_alloc [D];
    bit         m_done  [D];
    logic [W-1:0] m_res [D];
    logic [4:0] m_st    [D];
    logic       m_ext   [D];
    int         m_head = 0;
    int         m_count = 0;
    logic [4:0] m_ff = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < D; i++) begin
            m_alloc[i] = 0;
            m_done[i]  = 0;
            m_res[i]   = '0;
            m_st[i]    = '0;
            m_ext[i]   = 1'b0;
        end
        m_head  = 0;
        m_count = 0;
        m_ff    = '0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_clear();
        end else begin
            automatic int tail = (m_head + m_count) % D;
            automatic bit a = alloc_valid && (m_count != D) && !flush;
            automatic bit r = m_alloc[m_head] && m_done[m_head] && out_ready && !flush;
            automatic bit c = in_valid && m_alloc[int'(id_in)] && !m_done[int'(id_in)] && !flush;
            automatic logic [4:0] hs = m_st[m_head];
            if (fflags_clr) m_ff = r ? hs : 5'd0;
            else if (r) m_ff = m_ff | hs;
            if (flush) begin
                for (int i = 0; i < D; i++) begin
                    m_alloc[i] = 0;
                    m_done[i]  = 0;
                end
                m_head  = 0;
                m_count = 0;
            end else begin
                if (r) begin
                    m_alloc[m_head] = 0;
                    m_done[m_head]  = 0;
                    m_head  = (m_head + 1) % D;
                    m_count = m_count - 1;
                end
                if (c) begin
                    m_res[int'(id_in)]  = res_in;
                    m_st[int'(id_in)]   = st_in;
                    m_ext[int'(id_in)]  = ext_in;
                    m_done[int'(id_in)] = 1;
                end
                if (a) begin
                    m_alloc[tail] = 1;
                    m_done[tail]  = 0;
                    m_count = m_count + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cmp_alloc_ready", 32'(alloc_ready_o), 32'(m_count != D));
            chk("cmp_alloc_id", 32'(alloc_id_o), 32'((m_head + m_count) % D));
            chk("cmp_in_ready", 32'(in_ready_o), 32'd1);
            chk("cmp_out_valid", 32'(out_valid_o), 32'(m_alloc[m_head] && m_done[m_head]));
            chk("cmp_result", result_o, m_res[m_head]);
            chk("cmp_status", 32'(status_o), 32'(m_st[m_head]));
            chk("cmp_ext", 32'(extension_bit_o), 32'(m_ext[m_head]));
            chk("cmp_fflags", 32'(fflags_o), 32'(m_ff));
            chk("cmp_busy", 32'(busy_o), 32'(m_count != 0));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic alloc_n(input int n);
        alloc_valid = 1'b1;
        repeat (n) step();
        alloc_valid = 1'b0;
    endtask

    task automatic complete(input int id, input logic [31:0] r, input logic [4:0] s);
        in_valid = 1'b1;
        id_in    = id[IW-1:0];
        res_in   = r;
        st_in    = s;
        ext_in   = r[0];
        step();
        in_valid = 1'b0;
    endtask

    task automatic flush_all();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    initial begin
        int pend[$];
        model_clear();
        step();
        step();
        chk("rst_alloc_ready", 32'(alloc_ready_o), 32'd1);
        chk("rst_alloc_id", 32'(alloc_id_o), 32'd0);
        chk("rst_out_valid", 32'(out_valid_o), 32'd0);
        chk("rst_fflags", 32'(fflags_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_result", result_o, 32'd0);
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        // In-order completion with continuous writeback.
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("t1_alloc_id", 32'(alloc_id_o), 32'(i));
            alloc_n(1);
        end
        complete(0, 32'h3F800000, 5'h00);
        chk("t1_valid0", 32'(out_valid_o), 32'd1);
        chk("t1_res0", result_o, 32'h3F800000);
        complete(1, 32'h40000000, 5'h00);
        chk("t1_res1", result_o, 32'h40000000);
        complete(2, 32'h40400000, 5'h00);
        chk("t1_res2", result_o, 32'h40400000);
        step();
        chk("t1_drained", 32'(busy_o), 32'd0);

        // Out-of-order completion: 2, 0, 1.
        flush_all();
        alloc_n(3);
        complete(2, 32'h40400000, 5'h00);
        chk("t2_hold", 32'(out_valid_o), 32'd0);
        complete(0, 32'h3F800000, 5'h00);
        chk("t2_valid0", 32'(out_valid_o), 32'd1);
        chk("t2_res0", result_o, 32'h3F800000);
        step();
        chk("t2_gap", 32'(out_valid_o), 32'd0);
        complete(1, 32'h40000000, 5'h00);
        chk("t2_res1", result_o, 32'h40000000);
        step();
        chk("t2_valid2", 32'(out_valid_o), 32'd1);
        chk("t2_res2", result_o, 32'h40400000);
        step();
        chk("t2_done", 32'(out_valid_o), 32'd0);

        // Full and wrap.
        flush_all();
        out_ready = 1'b0;
        alloc_n(4);
        chk("t3_full_ready", 32'(alloc_ready_o), 32'd0);
        chk("t3_full_busy", 32'(busy_o), 32'd1);
        complete(0, 32'h11111111, 5'h01);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t3_ready_again", 32'(alloc_ready_o), 32'd1);
        chk("t3_wrap_id", 32'(alloc_id_o), 32'd0);
        alloc_n(1);
        complete(1, 32'h22222222, 5'h00);
        complete(2, 32'h33333333, 5'h00);
        complete(3, 32'h44444444, 5'h00);
        complete(0, 32'h55555555, 5'h00);
        out_ready = 1'b1;
        repeat (6) step();
        chk("t3_drained", 32'(busy_o), 32'd0);

        // Backpressure.
        flush_all();
        out_ready = 1'b0;
        alloc_n(1);
        complete(0, 32'hC0490FDB, 5'h15);
        for (int i = 0; i < 5; i++) begin
            chk("t4_valid", 32'(out_valid_o), 32'd1);
            chk("t4_res", result_o, 32'hC0490FDB);
            chk("t4_st", 32'(status_o), 32'h15);
            step();
        end
        out_ready = 1'b1;
        step();
        chk("t4_released", 32'(out_valid_o), 32'd0);
        chk("t4_single", 32'(busy_o), 32'd0);

        // Sticky flags and clear-with-retire.
        fflags_clr = 1'b1;
        step();
        fflags_clr = 1'b0;
        chk("t5_clr", 32'(fflags_o), 32'd0);
        alloc_n(3);
        complete(1, 32'h1, 5'h01);
        complete(2, 32'h2, 5'h05);
        chk("t5_nx", 32'(fflags_o), 32'h01);
        step();
        chk("t5_of_nx", 32'(fflags_o), 32'h05);
        complete(3, 32'h3, 5'h08);
        fflags_clr = 1'b1;
        step();
        fflags_clr = 1'b0;
        chk("t5_clr_dz", 32'(fflags_o), 32'h08);

        // Flush with pending slots, then a stale completion.
        out_ready = 1'b0;
        alloc_n(3);
        complete(0, 32'hDEADBEEF, 5'h02);
        chk("t6_pre", 32'(out_valid_o), 32'd1);
        flush_all();
        chk("t6_busy", 32'(busy_o), 32'd0);
        chk("t6_valid", 32'(out_valid_o), 32'd0);
        chk("t6_id", 32'(alloc_id_o), 32'd0);
        chk("t6_ff", 32'(fflags_o), 32'h08);
        complete(1, 32'hBADBAD00, 5'h1F);
        chk("t6_stale", 32'(out_valid_o), 32'd0);
        chk("t6_stale_busy", 32'(busy_o), 32'd0);

        // Random traffic with one mid-run reset.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc == 1500) rst_n = 1'b0;
            if (cyc == 1502) rst_n = 1'b1;
            alloc_valid = 1'($urandom_range(0, 1));
            out_ready   = ($urandom_range(0, 3) != 0);
            flush       = ($urandom_range(0, 63) == 0);
            fflags_clr  = ($urandom_range(0, 31) == 0);
            pend.delete();
            for (int i = 0; i < D; i++)
                if (m_alloc[i] && !m_done[i]) pend.push_back(i);
            in_valid = 1'b0;
            if (pend.size() != 0 && $urandom_range(0, 1) == 1) begin
                automatic int k = pend[$urandom_range(0, pend.size() - 1)];
                in_valid = 1'b1;
                id_in    = k[IW-1:0];
                res_in   = $urandom;
                st_in    = 5'($urandom);
                ext_in   = 1'($urandom);
            end
            step();
        end
        alloc_valid = 1'b0;
        in_valid    = 1'b0;
        flush       = 1'b0;
        fflags_clr  = 1'b0;
        out_ready   = 1'b1;
        repeat (3) step();
        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
